// File: rtl/conv_mac_acc.sv
// conv_mac_acc: pipelined KSIZE x KSIZE signed multiply-accumulate over
// CHANNELS input windows, producing one fixed-point convolution result per
// CHANNELS accepted beats.
//
// Pipeline: products -> row sums -> window sum -> channel accumulator/output.
// A single enable stalls every stage while a result waits on out_ready.
//
// Build option: define CONV_MAC_ACC_SATURATE_EN to clamp the shifted sum to
// the OUT_W signed range; otherwise the low OUT_W bits are kept (wrap).
module conv_mac_acc #(
  parameter int DATA_W     = 16,
  parameter int KSIZE      = 3,
  parameter int CHANNELS   = 4,
  parameter int FRAC_SHIFT = 14,
  parameter int OUT_W      = 18
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [KSIZE*KSIZE*DATA_W-1:0]   in_chunk,
  input  logic [KSIZE*KSIZE*DATA_W-1:0]   weight,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [OUT_W-1:0]         out_data
);

  localparam int N      = KSIZE * KSIZE;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ROW_W  = PROD_W + $clog2(KSIZE);
  localparam int WS_W   = PROD_W + $clog2(N);
  localparam int ACC_W  = WS_W + $clog2(CHANNELS);
  localparam int CNT_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNELS - 1);

`ifdef CONV_MAC_ACC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  logic en;

  logic signed [DATA_W-1:0] px [N];
  logic signed [DATA_W-1:0] wt [N];
  logic signed [PROD_W-1:0] prod_d [N];
  logic signed [ROW_W-1:0]  row_d [KSIZE];
  logic signed [WS_W-1:0]   ws_d;

  logic signed [PROD_W-1:0] prod_q [N];
  logic signed [ROW_W-1:0]  row_q [KSIZE];
  logic signed [WS_W-1:0]   ws_q;
  logic                     v1, v2, v3;

  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         chan_cnt;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  narrowed;
  logic                     last_ch;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Unpack windows (element (1,1) in the MSBs) and form per-element products.
  always_comb begin
    for (int e = 0; e < N; e++) begin
      px[e]     = in_chunk[(N-e)*DATA_W-1 -: DATA_W];
      wt[e]     = weight[(N-e)*DATA_W-1 -: DATA_W];
      prod_d[e] = PROD_W'(px[e]) * PROD_W'(wt[e]);
    end
  end

  // Row sums from registered products, then window sum from registered rows.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      row_d[r] = '0;
      for (int c = 0; c < KSIZE; c++) begin
        row_d[r] = row_d[r] + ROW_W'(prod_q[r*KSIZE+c]);
      end
    end
    ws_d = '0;
    for (int r = 0; r < KSIZE; r++) begin
      ws_d = ws_d + WS_W'(row_q[r]);
    end
  end

  // Channel accumulation and output narrowing of the completed sum.
  always_comb begin
    last_ch  = (chan_cnt == LAST_CH);
    acc_base = (chan_cnt == '0) ? '0 : acc;
    acc_sum  = acc_base + ACC_W'(ws_q);
    shifted  = acc_sum >>> FRAC_SHIFT;
`ifdef CONV_MAC_ACC_SATURATE_EN
    if (shifted > SAT_MAX) begin
      narrowed = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      narrowed = SAT_MIN[OUT_W-1:0];
    end else begin
      narrowed = OUT_W'(shifted);
    end
`else
    narrowed = OUT_W'(shifted);
`endif
  end

  // Pipeline registers, accumulator and output; everything holds while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < N; e++) prod_q[e] <= '0;
      for (int r = 0; r < KSIZE; r++) row_q[r] <= '0;
      ws_q      <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      acc       <= '0;
      chan_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      v1 <= in_valid;
      if (in_valid) begin
        for (int e = 0; e < N; e++) prod_q[e] <= prod_d[e];
      end
      v2 <= v1;
      if (v1) begin
        for (int r = 0; r < KSIZE; r++) row_q[r] <= row_d[r];
      end
      v3 <= v2;
      if (v2) begin
        ws_q <= ws_d;
      end
      out_valid <= v3 && last_ch;
      if (v3) begin
        acc <= acc_sum;
        if (last_ch) begin
          chan_cnt <= '0;
          out_data <= narrowed;
        end else begin
          chan_cnt <= chan_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_acc.sv
// Directed testbench for conv_mac_acc at default parameters.
module tb_conv_mac_acc;

  localparam int DATA_W = 16;
  localparam int N      = 9;
  localparam int OUT_W  = 18;

  logic                     clk;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [N*DATA_W-1:0]      in_chunk;
  logic [N*DATA_W-1:0]      weight;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;

  int errors = 0;
  int checks = 0;

  conv_mac_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_chunk  (in_chunk),
    .weight    (weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beats(input int n, input logic [15:0] pix, input logic [15:0] w);
    for (int i = 0; i < n; i++) begin
      in_chunk = {N{pix}};
      weight   = {N{w}};
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Called right after the edge accepting the last beat; returns edge count
  // (including that edge) until out_valid is seen, bounded.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_chunk = '0; weight = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 18'sd0) begin errors++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_ones();
    int lat;
    send_beats(3, 16'h0001, 16'h4000);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_early_valid got=%b exp=0", out_valid); end
    send_beats(1, 16'h0001, 16'h4000);
    wait_result(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ones_latency got=%0d exp=4", lat); end
    checks++; if (out_data !== 18'sd36) begin errors++; $display("FAIL ones_data got=%0d exp=36", out_data); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_valid_clear got=%b exp=0", out_valid); end
  endtask

  task automatic test_negative();
    int lat;
    send_beats(4, 16'hFFFF, 16'h4000);
    wait_result(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL neg_latency got=%0d exp=4", lat); end
    checks++; if (out_data !== -18'sd36) begin errors++; $display("FAIL neg_data got=%0d exp=-36", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int lat;
    logic signed [OUT_W-1:0] exp_v;
`ifdef CONV_MAC_ACC_SATURATE_EN
    exp_v = 18'sd131071;
`else
    exp_v = -18'sd144;
`endif
    send_beats(4, 16'h7FFF, 16'h7FFF);
    wait_result(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ovf_latency got=%0d exp=4", lat); end
    checks++; if (out_data !== exp_v) begin errors++; $display("FAIL ovf_data got=%0d exp=%0d", out_data, exp_v); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send_beats(4, 16'h0001, 16'h4000);
    wait_result(lat);
    checks++; if (lat !== 4 || out_data !== 18'sd36) begin
      errors++; $display("FAIL bp_first lat=%0d data=%0d exp 4/36", lat, out_data);
    end
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== 18'sd36) begin
        errors++; $display("FAIL bp_hold cyc=%0d valid=%b data=%0d exp 1/36", i, out_valid, out_data);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake_clear got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int spurious;
    send_beats(2, 16'hFFFF, 16'h4000);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    rst = 1'b0;
    send_beats(4, 16'h0001, 16'h4000);
    wait_result(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency got=%0d exp=4", lat); end
    checks++; if (out_data !== 18'sd36) begin errors++; $display("FAIL midrst_data got=%0d exp=36", out_data); end
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL midrst_extra_results got=%0d exp=0", spurious); end
  endtask

  task automatic test_back_to_back();
    int nres;
    int res_t [2];
    logic signed [OUT_W-1:0] res_d [2];
    nres = 0;
    res_t[0] = -1; res_t[1] = -1;
    res_d[0] = '0; res_d[1] = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < 8) begin
        in_chunk = (k < 4) ? {N{16'h0001}} : {N{16'hFFFF}};
        weight   = {N{16'h4000}};
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        if (nres < 2) begin
          res_t[nres] = k;
          res_d[nres] = out_data;
        end
        nres++;
      end
    end
    checks++; if (nres !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", nres); end
    checks++; if (res_t[0] !== 6 || res_d[0] !== 18'sd36) begin
      errors++; $display("FAIL b2b_first edge=%0d data=%0d exp 6/36", res_t[0], res_d[0]);
    end
    checks++; if (res_t[1] !== 10 || res_d[1] !== -18'sd36) begin
      errors++; $display("FAIL b2b_second edge=%0d data=%0d exp 10/-36", res_t[1], res_d[1]);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_negative();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
